// File: rtl/vector_alu_pkg.sv
// Shared types for the chunked vector ALU: operation codes, FSM states and a
// small ceiling-division helper used to derive the chunk count from a length.
package vector_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_CMP = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_NOT = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/vector_lane_op.sv
// One combinational element lane: result = op(a, b).
// With VECTOR_ALU_SAT_EN defined, add/sub clamp as signed and mul clamps unsigned.
module vector_lane_op
  import vector_alu_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int MULT_SHIFT = 0
) (
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  input  op_e             op_i,
  output logic [BITS-1:0] result_o
);

  logic [2*BITS-1:0] prod_full;
  logic              a_gt_b;

  assign prod_full = {{BITS{1'b0}}, a_i} * {{BITS{1'b0}}, b_i};
  assign a_gt_b    = $signed(a_i) > $signed(b_i);

`ifdef VECTOR_ALU_SAT_EN
  // One guard bit holds the exact signed sum/difference, so overflow is a
  // disagreement between the guard bit and the element sign bit.
  logic [BITS:0]     sum_ext;
  logic [BITS:0]     diff_ext;
  logic [2*BITS-1:0] prod_shift;

  assign sum_ext    = {a_i[BITS-1], a_i} + {b_i[BITS-1], b_i};
  assign diff_ext   = {a_i[BITS-1], a_i} - {b_i[BITS-1], b_i};
  assign prod_shift = prod_full >> MULT_SHIFT;

  function automatic logic [BITS-1:0] clamp_signed(input logic [BITS:0] v);
    if (v[BITS] != v[BITS-1]) begin
      return v[BITS] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
    end
    return v[BITS-1:0];
  endfunction
`else
  logic [BITS-1:0] sum_w;
  logic [BITS-1:0] diff_w;
  logic [BITS-1:0] prod_low;

  assign sum_w    = a_i + b_i;
  assign diff_w   = a_i - b_i;
  assign prod_low = BITS'(prod_full >> MULT_SHIFT);
`endif

  always_comb begin
    result_o = '0;
    case (op_i)
`ifdef VECTOR_ALU_SAT_EN
      OP_ADD: result_o = clamp_signed(sum_ext);
      OP_SUB: result_o = clamp_signed(diff_ext);
      OP_MUL: result_o = (|prod_shift[2*BITS-1:BITS]) ? {BITS{1'b1}} : prod_shift[BITS-1:0];
`else
      OP_ADD: result_o = sum_w;
      OP_SUB: result_o = diff_w;
      OP_MUL: result_o = prod_low;
`endif
      OP_CMP: begin
        if (a_gt_b)          result_o = {{(BITS-1){1'b0}}, 1'b1};
        else if (a_i == b_i) result_o = '0;
        else                 result_o = {BITS{1'b1}};
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_NOT: result_o = ~a_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/vector_chunk_alu.sv
// Multi-cycle vector ALU: LANES elements per cycle behind start/busy/done,
// operands latched at start. Saturating arithmetic under VECTOR_ALU_SAT_EN.
module vector_chunk_alu
  import vector_alu_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int N          = 64,
  parameter int LANES      = 8,
  parameter int LEN_W      = 8,
  parameter int MULT_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0][BITS-1:0]   A,
  input  logic [LEN_W-1:0]         A_len,
  input  logic [N-1:0][BITS-1:0]   B,
  input  logic [LEN_W-1:0]         B_len,
  input  logic [BITS-1:0]          scalar,
  input  logic                     scalar_sel,
  input  logic [2:0]               op_sel,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [N-1:0][BITS-1:0]   S,
  output logic [LEN_W-1:0]         S_len
);

  localparam int CHUNKS = N / LANES;
  localparam int CH_W   = $clog2(CHUNKS + 1);
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

  state_e                   state_q, state_d;
  logic [CH_W-1:0]          chunk_q, chunk_d;
  logic [N-1:0][BITS-1:0]   s_q, s_d;
  logic [LEN_W-1:0]         s_len_q, s_len_d;
  logic [N-1:0][BITS-1:0]   a_q, b_q;
  op_e                      op_q;

  logic [LEN_W-1:0]         raw_len, eff_len;
  logic                     start_accept;
  logic [BITS-1:0]          lane_a   [LANES];
  logic [BITS-1:0]          lane_b   [LANES];
  logic [BITS-1:0]          lane_res [LANES];

  always_comb begin
    raw_len = scalar_sel ? A_len : ((A_len > B_len) ? A_len : B_len);
    eff_len = raw_len;
    if (int'(raw_len) > N) eff_len = LEN_W'(N);
  end

  assign start_accept = (state_q == ST_IDLE) && start;

  // Operands only matter once captured, so they carry no reset.
  always_ff @(posedge clk) begin
    if (start_accept) begin
      a_q  <= A;
      op_q <= op_e'(op_sel);
      for (int i = 0; i < N; i++) begin
        b_q[i] <= scalar_sel ? scalar : B[i];
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_a[gi] = a_q[IDX_W'(int'(chunk_q) * LANES + gi)];
    assign lane_b[gi] = b_q[IDX_W'(int'(chunk_q) * LANES + gi)];

    vector_lane_op #(
      .BITS       (BITS),
      .MULT_SHIFT (MULT_SHIFT)
    ) u_lane (
      .a_i      (lane_a[gi]),
      .b_i      (lane_b[gi]),
      .op_i     (op_q),
      .result_o (lane_res[gi])
    );
  end

  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    s_d     = s_q;
    s_len_d = s_len_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          s_d     = '0;
          s_len_d = eff_len;
          chunk_d = '0;
          state_d = (eff_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Tail lanes past the result length are forced to zero.
        for (int j = 0; j < LANES; j++) begin
          if (int'(chunk_q) * LANES + j < int'(s_len_q))
            s_d[IDX_W'(int'(chunk_q) * LANES + j)] = lane_res[j];
          else
            s_d[IDX_W'(int'(chunk_q) * LANES + j)] = '0;
        end
        chunk_d = chunk_q + 1'b1;
        if (int'(chunk_q) == ceil_div(int'(s_len_q), LANES) - 1) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      chunk_q <= '0;
      s_q     <= '0;
      s_len_q <= '0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      s_q     <= s_d;
      s_len_q <= s_len_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign S     = s_q;
  assign S_len = s_len_q;

endmodule

// File: tb/tb_vector_chunk_alu.sv
// Bench for vector_chunk_alu: element-level reference model with per-cycle
// compare, directed literal cases and randomized operations.
module tb_vector_chunk_alu;

  localparam int BITS = 8, N = 64, LANES = 8, LEN_W = 8, MULT_SHIFT = 0;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N-1:0][BITS-1:0] A, B, S;
  logic [LEN_W-1:0]       A_len, B_len, S_len;
  logic [BITS-1:0]        scalar;
  logic                   scalar_sel, start, busy, done;
  logic [2:0]             op_sel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vector_chunk_alu #(
    .BITS(BITS), .N(N), .LANES(LANES), .LEN_W(LEN_W), .MULT_SHIFT(MULT_SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .A_len(A_len), .B(B), .B_len(B_len),
    .scalar(scalar), .scalar_sel(scalar_sel), .op_sel(op_sel), .start(start),
    .busy(busy), .done(done), .S(S), .S_len(S_len)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic per element.
  function automatic int sat_s(input int v);
`ifdef VECTOR_ALU_SAT_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
`endif
    return v;
  endfunction

  function automatic logic [7:0] ref_op(input int op, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      0: r = sat_s(sa + sb);
      1: r = sat_s(sa - sb);
      2: begin
        r = (int'(a) * int'(b)) >> MULT_SHIFT;
`ifdef VECTOR_ALU_SAT_EN
        if (r > 255) r = 255;
`endif
      end
      3: r = (sa > sb) ? 1 : ((sa == sb) ? 0 : 255);
      4: r = int'(a & b);
      5: r = int'(a | b);
      6: r = int'(a ^ b);
      default: r = int'(~a);
    endcase
    return r[7:0];
  endfunction

  function automatic int ref_len(input int alen, input int blen, input logic ssel);
    int l;
    l = ssel ? alen : ((alen > blen) ? alen : blen);
    return (l > N) ? N : l;
  endfunction

  function automatic logic [N-1:0][7:0] ref_vec(input int op, input int len, input logic ssel,
                                               input logic [7:0] sc,
                                               input logic [N-1:0][7:0] va,
                                               input logic [N-1:0][7:0] vb);
    logic [N-1:0][7:0] v;
    for (int i = 0; i < N; i++)
      v[i] = (i < len) ? ref_op(op, va[i], ssel ? sc : vb[i]) : 8'h00;
    return v;
  endfunction

  // Model state: busy flag, edges remaining until done, expected result.
  logic              m_busy;
  int                m_cnt;
  logic [N-1:0][7:0] m_S;
  logic [7:0]        m_len;
  wire               m_done = m_busy && (m_cnt == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_S    <= '0;
      m_len  <= '0;
    end else if (m_busy) begin
      if (m_cnt == 0) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt - 1;
    end else if (start) begin
      m_busy <= 1'b1;
      m_cnt  <= (ref_len(A_len, B_len, scalar_sel) + LANES - 1) / LANES;
      m_len  <= 8'(ref_len(A_len, B_len, scalar_sel));
      m_S    <= ref_vec(op_sel, ref_len(A_len, B_len, scalar_sel), scalar_sel, scalar, A, B);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (!m_busy || m_done) begin
        int bad;
        bad = 0;
        for (int i = N - 1; i >= 0; i--) if (S[i] !== m_S[i]) bad = i;
        chk("S_len", S_len, m_len);
        chk($sformatf("S[%0d]", bad), S[bad], m_S[bad]);
      end
      if (m_done) $display("txn done: op=%0d S_len=%0d S[0]=%0d t=%0t", op_sel, m_len, m_S[0], $time);
    end
  end

  task automatic run_op(input logic [2:0] op, input int alen, input int blen, input logic ssel,
                        input logic [7:0] sc, input bit scramble, output int lat);
    @(negedge clk);
    op_sel = op; A_len = 8'(alen); B_len = 8'(blen);
    scalar_sel = ssel; scalar = sc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      if (scramble) begin
        for (int i = 0; i < N; i++) begin
          A[i] = 8'($urandom);
          B[i] = 8'($urandom);
        end
        start = ($urandom_range(0, 3) == 0);
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, pulses, l;
    logic [2:0] rop;
    int ra, rb;
    logic rs;
    A = '0; B = '0; A_len = '0; B_len = '0; scalar = '0;
    scalar_sel = 1'b0; op_sel = '0; start = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_S_len", S_len, 0);
    chk("rst_S_any", int'(|S), 0);

    // Add, length 20, three chunks.
    for (int i = 0; i < N; i++) begin A[i] = 8'(i); B[i] = 8'd2; end
    run_op(3'd0, 20, 20, 1'b0, 8'd0, 1'b0, lat);
    chk("add_lat", lat, 3);
    chk("add_S0", S[0], 2);
    chk("add_S19", S[19], 21);
    chk("add_S20", S[20], 0);
    chk("add_len", S_len, 20);

    // Scalar multiply over the full vector.
    run_op(3'd2, 64, 5, 1'b1, 8'd3, 1'b0, lat);
    chk("mul_lat", lat, 8);
    chk("mul_S10", S[10], 30);
    chk("mul_S63", S[63], 189);
    chk("mul_len", S_len, 64);

    // Signed compare.
    A[0] = 8'd5; A[1] = 8'd3; A[2] = 8'h80;
    B[0] = 8'd3; B[1] = 8'd3; B[2] = 8'h01;
    run_op(3'd3, 3, 3, 1'b0, 8'd0, 1'b0, lat);
    chk("cmp_S0", S[0], 8'h01);
    chk("cmp_S1", S[1], 8'h00);
    chk("cmp_S2", S[2], 8'hFF);

    // Zero length, with start held into the DONE cycle.
    @(negedge clk);
    A_len = '0; B_len = '0; scalar_sel = 1'b0; op_sel = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    chk("zl_done", done, 1);
    chk("zl_len", S_len, 0);
    chk("zl_S0", S[0], 0);
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("zl_extra_pulses", pulses, 0);

    // Saturation corner cases.
    A[0] = 8'h7F; B[0] = 8'h01;
    run_op(3'd0, 1, 1, 1'b0, 8'd0, 1'b0, lat);
`ifdef VECTOR_ALU_SAT_EN
    chk("sat_add", S[0], 8'h7F);
`else
    chk("wrap_add", S[0], 8'h80);
`endif
    A[0] = 8'h80; B[0] = 8'h01;
    run_op(3'd1, 1, 1, 1'b0, 8'd0, 1'b0, lat);
`ifdef VECTOR_ALU_SAT_EN
    chk("sat_sub", S[0], 8'h80);
`else
    chk("wrap_sub", S[0], 8'h7F);
`endif
    A[0] = 8'h20; B[0] = 8'h10;
    run_op(3'd2, 1, 1, 1'b0, 8'd0, 1'b0, lat);
`ifdef VECTOR_ALU_SAT_EN
    chk("sat_mul", S[0], 8'hFF);
`else
    chk("wrap_mul", S[0], 8'h00);
`endif

    // Reset in the middle of a run, after two chunks have been written.
    for (int i = 0; i < N; i++) begin A[i] = 8'(i + 1); B[i] = 8'd1; end
    @(negedge clk);
    op_sel = 3'd0; A_len = 8'd64; B_len = 8'd64; scalar_sel = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_len", S_len, 0);
    chk("mid_rst_S_any", int'(|S), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin A[i] = 8'(i); B[i] = 8'd2; end
    run_op(3'd0, 20, 20, 1'b0, 8'd0, 1'b0, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_S19", S[19], 21);

    // Randomized operations with inputs scrambled and stray starts while busy.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        A[i] = 8'($urandom);
        B[i] = 8'($urandom);
      end
      rop = 3'($urandom_range(0, 7));
      ra = $urandom_range(0, 80);
      rb = $urandom_range(0, 80);
      rs = 1'($urandom_range(0, 1));
      l = ref_len(ra, rb, rs);
      run_op(rop, ra, rb, rs, 8'($urandom), 1'b1, lat);
      chk("rnd_lat", lat, (l + LANES - 1) / LANES);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vector_chunk_alu.md
Name: vector_chunk_alu

Overview:
Multi-cycle, parametrised successor to the single-cycle per-element vector ALU. It computes element-wise ops over an N-element vector using LANES parallel lanes, one chunk of LANES elements per cycle, behind a start/busy/done handshake. Operands are latched at start, so the host/bus side may change inputs while the block runs. It sits between the vector register file and the result writeback path.

Parameters:
BITS, 8, element width in bits
N, 64, vector capacity in elements; must be a multiple of LANES
LANES, 8, elements computed per cycle; 1 <= LANES <= N
LEN_W, 8, width of the length ports; must be at least $clog2(N+1)
MULT_SHIFT, 0, right shift applied to the full 2*BITS product before taking the low BITS

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
A  in  [BITS-1:0] x N  operand vector A
A_len  in  LEN_W  valid length of A
B  in  [BITS-1:0] x N  operand vector B
B_len  in  LEN_W  valid length of B
scalar  in  BITS  scalar operand
scalar_sel  in  1  1: B operand = scalar for every element
op_sel  in  3  operation code
start  in  1  request; accepted only in IDLE
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse when the result is complete
S  out  [BITS-1:0] x N  result vector, registered
S_len  out  LEN_W  result length, registered

Behaviour:
- Reset (async, rst_n=0): state IDLE; S all 0; S_len 0; busy 0; done 0; internal chunk counter 0. Reset mid-RUN aborts and clears all of the above.
- Length: L = scalar_sel ? A_len : max(A_len, B_len), clipped to N. Chunk count C = ceil(L/LANES).
- FSM states: IDLE, RUN, DONE.
- IDLE and start=1 at edge t0:
  - Latch A, B (or scalar), op_sel and scalar_sel.
  - S_len <= L; all S <= 0; chunk <= 0.
  - Next state RUN if C > 0, else DONE.
- RUN: each edge writes S[k*LANES+j] for j = 0..LANES-1, where k is the current chunk.
  - Index < L: write the lane result.
  - Index >= L: write 0.
  - chunk increments. After chunk C-1 is written, next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy falls with done.
- Latency: done is high in cycle t0+C+1. For L=0, done is high in cycle t0+1.
- start while busy=1 is ignored and not queued. S, S_len hold between operations.
- Ops, on latched operands:
  - 000 add, 001 sub: result modulo 2^BITS.
  - 010 mul: (A*B unsigned, 2*BITS wide) >> MULT_SHIFT, low BITS.
  - 011 cmp, signed: A>B gives 1, A==B gives 0, A<B gives all-ones.
  - 100 and, 101 or, 110 xor, 111 ~A (B ignored).
- Lane datapath is combinational; there is no pipeline inside a chunk.

Optional Feature:
VECTOR_ALU_SAT_EN
- Defined: add, sub and mul saturate.
  - add/sub treat operands as signed and clamp to [-2^(BITS-1), 2^(BITS-1)-1].
  - mul is unsigned and clamps the shifted product to 2^BITS-1.
- Undefined: wrap-around as described above. Logic and cmp ops are unaffected either way.

Decomposition:
- Package vector_alu_pkg:
  - op_e enum: OP_ADD, OP_SUB, OP_MUL, OP_CMP, OP_AND, OP_OR, OP_XOR, OP_NOT.
  - state_e enum: ST_IDLE, ST_RUN, ST_DONE.
- One combinational sub-module, vector_lane_op (A, B, op → result), instantiated LANES times through generate. Saturation logic lives inside it under the macro.

Test Plan:
- BITS=8, N=64, LANES=8; A[i]=i, B[i]=2, A_len=B_len=20, op add, start → done at t0+4 (C=3); S[0..19]=i+2; S[20..63]=0; S_len=20.
- scalar_sel=1, scalar=3, A_len=64, B_len=5, op mul, MULT_SHIFT=0, A[i]=i → S_len=64; S[i]=(3i) mod 256 (S[63]=189); done at t0+9.
- op cmp, A={5, 3, 0x80}, B={3, 3, 0x01}, len 3 → S={0x01, 0x00, 0xFF}.
- A_len=B_len=0, start → done at t0+1, S all 0, S_len=0; a second start while busy is ignored, so only one done pulse.
- rst_n low during RUN (after chunk 1) → busy, done, S, S_len go to 0 immediately; the next start runs normally.
- With VECTOR_ALU_SAT_EN defined:
  - add 0x7F+0x01 gives 0x7F; sub 0x80-0x01 gives 0x80; mul 0x20*0x10 gives 0xFF.
  - Without the macro these give 0x80, 0x7F and 0x00.
